// File: rtl/clock_mode_scan_ctrl.sv
// Run/pause/adjust mode sequencer plus 4-digit display scan with blinking of
// the field being adjusted. Everything observable is registered on clk50hz.
module clock_mode_scan_ctrl #(
  parameter int BLINK_DIV = 6,
  parameter int BLINK_W   = 4
) (
  input  logic       clk50hz,
  input  logic       reset,
  input  logic       pause_btn,
  input  logic       adjust,
  input  logic       adj_sel,
  input  logic [3:0] min_ten,
  input  logic [3:0] min_one,
  input  logic [3:0] sec_ten,
  input  logic [3:0] sec_one,
  output logic [1:0] mode,
  output logic       sec_en,
  output logic       min_en,
  output logic       fast_rate,
  output logic [1:0] digit_sel,
  output logic [3:0] digit_val,
  output logic [3:0] anode,
  output logic       blink_phase
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    PAUSE   = 2'b01,
    ADJ_SEC = 2'b10,
    ADJ_MIN = 2'b11
  } state_t;

  state_t               state, state_d;
  logic                 pause_btn_q;
  logic                 btn_rise;
  logic [1:0]           scan_idx;
  logic [BLINK_W-1:0]   blink_cnt, blink_cnt_d;
  logic                 blink_d;
  logic [3:0]           val_mux;
  logic [3:0]           anode_d;
  logic                 sec_en_d, min_en_d, fast_d;

  assign btn_rise = pause_btn & ~pause_btn_q;
  assign mode     = state;

  always_comb begin
    state_d = state;
    if (adjust)
      state_d = adj_sel ? ADJ_MIN : ADJ_SEC;
    else if (state[1])
      state_d = RUN;
    else if (btn_rise)
      state_d = (state == RUN) ? PAUSE : RUN;
  end

  // Counter only advances while staying in adjust; entering or leaving clears it.
  always_comb begin
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if (state_d[1] && state[1]) begin
      if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_phase;
      end else begin
        blink_cnt_d = blink_cnt + 1'b1;
        blink_d     = blink_phase;
      end
    end
  end

  always_comb begin
    case (scan_idx)
      2'd0:    val_mux = min_ten;
      2'd1:    val_mux = min_one;
      2'd2:    val_mux = sec_ten;
      default: val_mux = sec_one;
    endcase
    // Mask uses the blink value being registered so anode and blink_phase agree.
    anode_d = ~(4'b1000 >> scan_idx);
    if (blink_d && state_d == ADJ_SEC) anode_d[1:0] = 2'b11;
    if (blink_d && state_d == ADJ_MIN) anode_d[3:2] = 2'b11;
  end

  always_comb begin
    sec_en_d = 1'b0;
    min_en_d = 1'b0;
    fast_d   = 1'b0;
    case (state_d)
      RUN:     begin sec_en_d = 1'b1; min_en_d = 1'b1; end
      ADJ_SEC: begin sec_en_d = 1'b1; fast_d   = 1'b1; end
      ADJ_MIN: begin min_en_d = 1'b1; fast_d   = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk50hz) begin
    if (reset) begin
      state       <= RUN;
      pause_btn_q <= 1'b0;
      scan_idx    <= 2'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      sec_en      <= 1'b0;
      min_en      <= 1'b0;
      fast_rate   <= 1'b0;
      digit_sel   <= 2'd0;
      digit_val   <= 4'd0;
      anode       <= 4'b1111;
    end else begin
      state       <= state_d;
      pause_btn_q <= pause_btn;
      scan_idx    <= scan_idx + 2'd1;
      blink_cnt   <= blink_cnt_d;
      blink_phase <= blink_d;
      sec_en      <= sec_en_d;
      min_en      <= min_en_d;
      fast_rate   <= fast_d;
      digit_sel   <= scan_idx;
      digit_val   <= val_mux;
      anode       <= anode_d;
    end
  end

endmodule
